reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Shares the register file's single write port among several writers: pipeline writeback, a late multicycle/load unit and a debug writer. Each cycle it picks at most one valid request by round-robin, completes a valid/ready handshake with it, and registers the winning write onto the register file write port one cycle later. It sits directly in front of the register file's write inputs; the read ports are not touched.

## Interface
- NREQ, 3: number of requesters, 2..8; index 0 = writeback, 1 = load/multicycle, 2 = debug
- CNT_W, 16: width of the write counter
- iCLK  in  1  clock; all state updates on the rising edge
- iRST  in  1  synchronous, active-high reset
- iReqValid  in  NREQ  request valid, one bit per requester
- iReqReg  in  NREQ*5  destination register; requester k uses bits [5k+4:5k]
- iReqData  in  NREQ*32  write data; requester k uses bits [32k+31:32k]
- oReqReady  out  NREQ  grant/accept, one-hot or zero, combinational
- iStall  in  1  freezes arbitration; no requester is accepted while high
- oRegWrite  out  1  register file write enable, registered
- oWriteRegister  out  5  register file write address, registered
- oWriteData  out  32  register file write data, registered
- oGrantId  out  3  index of the requester whose write is on the port, registered
- oWriteCount  out  CNT_W  number of writes issued with oRegWrite=1, wrapping

## Operation
- Handshake: a transfer completes on an edge where iReqValid[k] and oReqReady[k] are both 1. A requester holds valid, reg and data stable until accepted. Ready may depend on valid.
- Arbitration, combinational:
  - When iRST or iStall is high, oReqReady = 0.
  - Otherwise exactly one bit of oReqReady is set if any valid bit is set; the winner is the first valid index searching upward, wrapping, from the priority pointer ptr.
- Pointer: on an accept from k, ptr <= (k+1) mod NREQ. With no accept, ptr holds.
- Output register, on every edge (not in reset):
  - On an accept: oRegWrite <= (reg != 0); oWriteRegister <= reg; oWriteData <= data; oGrantId <= k.
  - With no accept: oRegWrite <= 0. Address, data and id hold their values.
- Register x0: the request is accepted and consumed, but no write is issued and the counter is not incremented.
- Counter: oWriteCount increments by 1 on each edge where the registered oRegWrite is 1. It wraps from 2^CNT_W-1 to 0.
- Ordering: two requesters writing the same register land in grant order; the last granted wins.
- The block assumes no write-read forwarding. The register file sees the write on the edge after oRegWrite rises.

## Timing
- Latency: accepted on edge N; oRegWrite high during cycle N..N+1; register file updated on edge N+1.
- Throughput: one write per cycle. Back-to-back grants produce continuous oRegWrite.
- Reset, synchronous, while iRST is sampled high:
  - Outputs: oRegWrite=0, oWriteRegister=0, oWriteData=0, oGrantId=0, oWriteCount=0, oReqReady=0.
  - Internal: ptr=0.
- Reset mid-operation: a write already in the output register is dropped. No accept occurs in a reset cycle.
- Stall:
  - No new accepts while iStall is high.
  - A write registered before the stall still issues in the next cycle.
  - oRegWrite=0 from the cycle after the first stalled edge.
- All requesters valid every cycle: grants rotate 0,1,2,0,… Each requester waits at most NREQ-1 cycles.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration as described.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, where the lowest valid index wins. ptr is not implemented (equivalent to constant 0). All other behaviour is identical.

## Structure
- Shared package:
  - REG_ADDR_W = 5, XLEN = 32.
  - Requester index constants REQ_WB = 0, REQ_MEM = 1, REQ_DBG = 2.
  - Default NREQ.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant and encoded index.
  - Reused for fixed priority with the pointer tied to 0.

## Test plan
- Reset release, no requests → all outputs 0 for 5 cycles. Then a single request k=1 (reg 5, data 0xDEADBEEF) → oReqReady=3'b010 in the same cycle; next cycle oRegWrite=1, oWriteRegister=5, oWriteData=0xDEADBEEF, oGrantId=1; oWriteCount=1 after that.
- All three requesters valid continuously for 6 cycles → grant sequence 0,1,2,0,1,2; oRegWrite high for 6 consecutive cycles. Without ARB_ROUND_ROBIN_EN → 0 granted every cycle.
- Request to reg 0 with data 0x1234 → accepted (ready=1), oRegWrite stays 0, oWriteCount unchanged.
- iStall high for 3 cycles with requesters 0 and 2 valid → oReqReady=0 throughout. After release → requester 0 is granted (ptr=0), then 2.
- iRST asserted in the cycle after an accept to reg 7 → oRegWrite=0, outputs cleared, and reg 7 is never written.
- Set CNT_W=4 and issue 17 writes → oWriteCount reads 1.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reg_write_arbiter_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN         = 32;
  localparam int ID_W         = 3;   // enough for up to 8 requesters
  localparam int NREQ_DEFAULT = 3;

  // Requester slots
  localparam int REQ_WB  = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_DBG = 2;

  // Contents of the registered write port
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
    logic [ID_W-1:0]       id;
  } wr_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller masks req to suppress grants.
module reg_write_arbiter_rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int N = NREQ_DEFAULT
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_vld
);

  int idx;

  // Walk the requests starting at ptr; the first one found wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates NREQ writers onto the single register-file write port (ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority).
// Latency: accept on edge N, write presented on the port for cycle N..N+1.
// Backpressure: oReqReady is withheld while iStall or iRST is high; writes already registered still issue.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic [NREQ-1:0]            iReqValid,
  input  logic [NREQ*REG_ADDR_W-1:0] iReqReg,
  input  logic [NREQ*XLEN-1:0]       iReqData,
  output logic [NREQ-1:0]            oReqReady,
  input  logic                       iStall,
  output logic                       oRegWrite,
  output logic [REG_ADDR_W-1:0]      oWriteRegister,
  output logic [XLEN-1:0]            oWriteData,
  output logic [ID_W-1:0]            oGrantId,
  output logic [CNT_W-1:0]           oWriteCount
);

  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  gnt_vld;
  logic [ID_W-1:0]       ptr;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [XLEN-1:0]       sel_dat;
  wr_t                   wr_q;
  logic [CNT_W-1:0]      cnt_q;

  // Nobody may be accepted during reset or stall.
  assign req_vld = (iRST || iStall) ? '0 : iReqValid;

  reg_write_arbiter_rr_pick #(.N(NREQ)) u_rr_pick (
    .req     (req_vld),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign oReqReady = gnt;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q;

  // Priority moves to the slot just after the last accepted requester.
  always_ff @(posedge iCLK) begin
    if (iRST)
      ptr_q <= '0;
    else if (gnt_vld)
      ptr_q <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign ptr = ptr_q;
`else
  // Fixed priority: lowest index always searched first.
  assign ptr = '0;
`endif

  // Route the winner's address and data using the one-hot grant.
  always_comb begin
    sel_reg = '0;
    sel_dat = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_reg = iReqReg[k*REG_ADDR_W +: REG_ADDR_W];
        sel_dat = iReqData[k*XLEN +: XLEN];
      end
    end
  end

  // Register the accepted write; x0 is consumed without a write enable.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_q <= '0;
    end else if (gnt_vld) begin
      wr_q.we   <= (sel_reg != '0);
      wr_q.addr <= sel_reg;
      wr_q.data <= sel_dat;
      wr_q.id   <= gnt_idx;
    end else begin
      wr_q.we <= 1'b0;
    end
  end

  // Count writes as they are issued to the register file, wrapping.
  always_ff @(posedge iCLK) begin
    if (iRST)
      cnt_q <= '0;
    else if (wr_q.we)
      cnt_q <= cnt_q + 1'b1;
  end

  // A write still sitting in the output register when reset hits is dropped.
  assign oRegWrite      = wr_q.we & ~iRST;
  assign oWriteRegister = wr_q.addr;
  assign oWriteData     = wr_q.data;
  assign oGrantId       = wr_q.id;
  assign oWriteCount    = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus random traffic against a behavioural model.
// Latency: model expects the accepted write on the port one cycle after the accepting edge.
// Backpressure: random iStall/iRST; requesters hold their request until accepted.
module tb_reg_write_arbiter;

  localparam int NREQ  = 3;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   iReqValid = '0;
  logic [NREQ*5-1:0] iReqReg = '0;
  logic [NREQ*32-1:0] iReqData = '0;
  logic              iStall = 1'b0;
  logic [NREQ-1:0]   oReqReady;
  logic              oRegWrite;
  logic [4:0]        oWriteRegister;
  logic [31:0]       oWriteData;
  logic [2:0]        oGrantId;
  logic [CNT_W-1:0]  oWriteCount;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .iCLK           (clk),
    .iRST           (rst),
    .iReqValid      (iReqValid),
    .iReqReg        (iReqReg),
    .iReqData       (iReqData),
    .oReqReady      (oReqReady),
    .iStall         (iStall),
    .oRegWrite      (oRegWrite),
    .oWriteRegister (oWriteRegister),
    .oWriteData     (oWriteData),
    .oGrantId       (oGrantId),
    .oWriteCount    (oWriteCount)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit reg7_written = 1'b0;

  // Behavioural model state
  int        m_ptr  = 0;
  bit        m_we   = 1'b0;
  bit [4:0]  m_addr = '0;
  bit [31:0] m_data = '0;
  int        m_id   = 0;
  int        m_cnt  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [NREQ-1:0] v, int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [4:0] reg_of(int k);
    return iReqReg[5*k +: 5];
  endfunction

  function automatic logic [31:0] dat_of(int k);
    return iReqData[32*k +: 32];
  endfunction

  // Model advance on every rising edge from the inputs present at that edge.
  always @(posedge clk) begin : model
    int w;
    if (rst) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_id = 0; m_cnt = 0;
    end else begin
      if (m_we) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      w = iStall ? -1 : pick(iReqValid, m_ptr);
      if (w >= 0) begin
        m_we   = (reg_of(w) != 5'd0);
        m_addr = reg_of(w);
        m_data = dat_of(w);
        m_id   = w;
`ifdef ARB_ROUND_ROBIN_EN
        m_ptr  = (w + 1) % NREQ;
`endif
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin : compare
    logic [NREQ-1:0] exp_rdy;
    int w;
    exp_rdy = '0;
    if (!rst && !iStall) begin
      w = pick(iReqValid, m_ptr);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    chk("model_ready", 32'(oReqReady), 32'(exp_rdy));
    chk("model_we",    32'(oRegWrite), 32'(m_we && !rst));
    chk("model_addr",  32'(oWriteRegister), 32'(m_addr));
    chk("model_data",  oWriteData, m_data);
    chk("model_id",    32'(oGrantId), 32'(m_id));
    chk("model_cnt",   32'(oWriteCount), 32'(m_cnt));
    if (oRegWrite && oWriteRegister == 5'd7) reg7_written = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [NREQ-1:0] acc;
    int exp_g;

    // Reset, then five idle cycles
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_we", 32'(oRegWrite), 32'd0);
      chk("idle_cnt", 32'(oWriteCount), 32'd0);
    end

    // Single request from requester 1
    step();
    iReqValid = 3'b010; iReqReg[5 +: 5] = 5'd5; iReqData[32 +: 32] = 32'hDEADBEEF;
    @(negedge clk); chk("single_ready", 32'(oReqReady), 32'b010);
    step(); iReqValid = '0;
    @(negedge clk);
    chk("single_we", 32'(oRegWrite), 32'd1);
    chk("single_addr", 32'(oWriteRegister), 32'd5);
    chk("single_data", oWriteData, 32'hDEADBEEF);
    chk("single_id", 32'(oGrantId), 32'd1);
    step();
    @(negedge clk);
    chk("single_cnt", 32'(oWriteCount), 32'd1);
    chk("single_we_off", 32'(oRegWrite), 32'd0);

    // All requesters valid for six cycles
    step(); rst = 1'b1; step(); rst = 1'b0;
    iReqValid = 3'b111;
    iReqReg  = {5'd3, 5'd2, 5'd1};
    iReqData = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = i % 3;
`else
      exp_g = 0;
`endif
      @(negedge clk);
      chk("rot_ready", 32'(oReqReady), 32'(1 << exp_g));
      if (i > 0) chk("rot_we", 32'(oRegWrite), 32'd1);
      step();
    end
    iReqValid = '0;
    @(negedge clk); chk("rot_we_last", 32'(oRegWrite), 32'd1);
    step();

    // Write to x0 is consumed silently; six writes counted so far
    iReqValid = 3'b001; iReqReg[0 +: 5] = 5'd0; iReqData[0 +: 32] = 32'h1234;
    @(negedge clk);
    chk("x0_ready", 32'(oReqReady), 32'b001);
    chk("x0_cnt_before", 32'(oWriteCount), 32'd6);
    step(); iReqValid = '0;
    @(negedge clk);
    chk("x0_we", 32'(oRegWrite), 32'd0);
    step();
    @(negedge clk);
    chk("x0_cnt_after", 32'(oWriteCount), 32'd6);

    // Stall with requesters 0 and 2 pending
    step(); rst = 1'b1; step(); rst = 1'b0;
    iStall = 1'b1; iReqValid = 3'b101;
    iReqReg = {5'd9, 5'd0, 5'd8}; iReqData = {32'h2222, 32'h0, 32'h1111};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("stall_ready", 32'(oReqReady), 32'd0);
      step();
    end
    iStall = 1'b0;
    @(negedge clk); chk("unstall_first", 32'(oReqReady), 32'b001);
    step(); iReqValid = 3'b100;
    @(negedge clk);
    chk("unstall_second", 32'(oReqReady), 32'b100);
    chk("unstall_id0", 32'(oGrantId), 32'd0);
    step(); iReqValid = '0;
    @(negedge clk); chk("unstall_id2", 32'(oGrantId), 32'd2);
    step();

    // Reset arrives right after accepting a write to reg 7
    reg7_written = 1'b0;
    iReqValid = 3'b001; iReqReg[0 +: 5] = 5'd7; iReqData[0 +: 32] = 32'h7777;
    @(negedge clk); chk("r7_ready", 32'(oReqReady), 32'b001);
    step(); iReqValid = '0; rst = 1'b1;
    @(negedge clk); chk("r7_we_dropped", 32'(oRegWrite), 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("r7_addr_clr", 32'(oWriteRegister), 32'd0);
    chk("r7_data_clr", oWriteData, 32'd0);
    chk("r7_cnt_clr", 32'(oWriteCount), 32'd0);
    chk("r7_never_written", 32'(reg7_written), 32'd0);

    // Seventeen writes wrap a 4-bit counter to 1
    step();
    iReqValid = 3'b100; iReqReg[10 +: 5] = 5'd3; iReqData[64 +: 32] = 32'h5555;
    repeat (17) step();
    iReqValid = '0;
    step();
    @(negedge clk); chk("wrap_cnt", 32'(oWriteCount), 32'd1);

    // Random traffic with occasional stall and reset
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = iReqValid & oReqReady;
      step();
      rst    = ($urandom_range(0, 99) < 2);
      iStall = ($urandom_range(0, 99) < 15);
      for (int k = 0; k < NREQ; k++) begin
        if (acc[k] || !iReqValid[k]) begin
          iReqValid[k] = 1'($urandom_range(0, 1));
          iReqReg[5*k +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          iReqData[32*k +: 32] = $urandom;
        end
      end
    end
    rst = 1'b0; iStall = 1'b0; iReqValid = '0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
